// File: rtl/fc_pkg.sv
// Shared FC-layer package: layer geometry defaults and the F6->FC2 fetch FSM encoding.
package fc_pkg;
  localparam int FC_N_IN = 120;
  localparam int FC_AW   = 7;
  localparam int FC_DW   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } fc2_state_e;
endpackage

// File: rtl/fc2_fetch_fifo.sv
// Synchronous FIFO with a registered occupancy count; head is always visible on rdata.
module fc2_fetch_fifo #(
  parameter int W     = 23,
  parameter int DEPTH = 4,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wp, rp;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign empty = (count == '0);
endmodule

// File: rtl/fc2_fetch.sv
// Streams F6 entries 0..N_IN-1 through a fixed-latency read port into a ready/valid beat stream.
module fc2_fetch
  import fc_pkg::*;
#(
  parameter int N_IN       = FC_N_IN,
  parameter int AW         = FC_AW,
  parameter int DW         = FC_DW,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] f6_raddr,
  input  logic [DW-1:0] f6_rdata,
  output logic          d_valid,
  input  logic          d_ready,
  output logic [DW-1:0] d_data,
  output logic [AW-1:0] d_index,
  output logic          d_last,
  output logic          busy,
  output logic          done
);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + RD_LAT + 2);

  fc2_state_e                  state;
  logic [AW-1:0]               cnt, raddr_q;
  logic [RD_LAT-1:0]           vld_pipe;
  logic [RD_LAT-1:0][AW-1:0]   idx_pipe;
  logic [FCW-1:0]              occ;
  logic [CW-1:0]               inflight;
  logic                        credit_ok, issue, pop, empty;
  logic [DW+AW-1:0]            head;

  // Every issued read already owns a FIFO slot, so the buffer can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  assign credit_ok = (CW'(occ) + inflight) < CW'(FIFO_DEPTH);
  assign issue     = (state == FETCH) && credit_ok;
  assign f6_raddr  = issue ? cnt : raddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      idx_pipe[0] <= cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  fc2_fetch_fifo #(.W(DW + AW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_pipe[RD_LAT-1]),
    .wdata ({f6_rdata, idx_pipe[RD_LAT-1]}),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .count (occ)
  );

  assign d_valid           = !empty;
  assign {d_data, d_index} = head;
  assign d_last            = (d_index == AW'(N_IN - 1));
  assign pop               = d_valid && d_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      raddr_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        FETCH: if (issue) begin
          raddr_q <= cnt;
          // Counter parks on the last address instead of wrapping.
          if (cnt == AW'(N_IN - 1)) state <= DRAIN;
          else                      cnt   <= cnt + 1'b1;
        end
        DRAIN: if (pop && d_last) begin
          state <= FIN;
          done  <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc2_fetch.sv
// Directed bench for fc2_fetch: full passes under several d_ready patterns, restart, reset and stall.
module tb_fc2_fetch;
  import fc_pkg::*;
  localparam int N_IN = 120, AW = 7, DW = 16, RD_LAT = 2, FD = 4;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, d_ready = 1'b0;
  logic [AW-1:0] f6_raddr, d_index;
  logic [DW-1:0] f6_rdata, d_data;
  logic          d_valid, d_last, busy, done;
  logic [AW-1:0] a1, a2;
  int            n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  // F6 model: two-cycle read port holding 1000+i at address i.
  always @(posedge clk) begin
    a1 <= f6_raddr;
    a2 <= a1;
  end
  assign f6_rdata = DW'(1000) + DW'(a2);

  fc2_fetch #(.N_IN(N_IN), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FD)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .f6_raddr (f6_raddr),
    .f6_rdata (f6_rdata),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_data   (d_data),
    .d_index  (d_index),
    .d_last   (d_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 ready=1, 1 random 30%, 2 low for 20 cycles, 3 stall last beat 5 cycles,
  //       4 second start at beat 50, 5 reset at beat 60
  task automatic run_pass(input int mode);
    int nb = 0, ndone = 0, done_cyc = 0, hs_first = -1, hs_last = 0;
    int maxocc = 0, occ = 0, stall = 0, extra = 0;
    bit quit = 0, pulsed = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 3000 && !quit && ndone == 0; k++) begin
      case (mode)
        1: d_ready = ($urandom_range(0, 99) < 30);
        2: d_ready = (k > 20);
        3: begin
          d_ready = !(d_valid && d_last && stall < 5);
          if (!d_ready) stall++;
        end
        default: d_ready = 1'b1;
      endcase
      start = (mode == 4 && nb == 50 && !pulsed);
      if (start) pulsed = 1;
      if (mode == 5 && nb == 60) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(d_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_raddr", 32'(f6_raddr), 0);
        quit = 1;
      end else begin
        @(negedge clk);
        occ = int'(u_dut.u_fifo.count);
        if (occ > maxocc) maxocc = occ;
        if (mode == 2 && (k == 10 || k == 20)) begin
          chk("stall_valid", 32'(d_valid), 1);
          chk("stall_index", 32'(d_index), 0);
          chk("stall_raddr", 32'(f6_raddr), 3);
          if (k == 20) chk("stall_occ", 32'(occ), 4);
        end
        if (k == 60) chk("busy_mid", 32'(busy), 1);
        if (d_valid && d_ready) begin
          if (hs_first < 0) hs_first = k;
          chk("beat_index", 32'(d_index), 32'(nb));
          chk("beat_data", 32'(d_data), 32'(1000 + nb));
          chk("beat_last", 32'(d_last), 32'(nb == N_IN - 1));
          nb++;
          hs_last = k;
        end
        if (done) begin
          ndone++;
          done_cyc = k;
        end
        @(posedge clk); #1;
      end
    end
    if (!quit) begin
      chk("beats", 32'(nb), 32'(N_IN));
      chk("done_seen", 32'(ndone), 1);
      chk("done_after_last", 32'(done_cyc), 32'(hs_last + 1));
      chk("occ_bound", 32'(maxocc <= FD), 1);
      if (mode == 0) begin
        chk("done_cycle", 32'(done_cyc), 32'(N_IN + RD_LAT + 2));
        chk("throughput", 32'(hs_last - hs_first), 32'(N_IN - 1));
      end
      if (mode == 3) chk("stall_cycles", 32'(stall), 5);
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("busy_after", 32'(busy), 0);
      chk("extra_done", 32'(extra), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(d_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_raddr", 32'(f6_raddr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(0);
    run_pass(2);
    run_pass(1);
    run_pass(4);
    run_pass(3);
    run_pass(5);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
